poly_sound: RTL

- Parametrised multi-voice successor to the single-tone sound block.
- Plays NUM_CHANNELS independent square-wave voices, each with an optional millisecond-tick duration.
- Mixes the voices onto the single buzzer pin with a first-order sigma-delta modulator.
- Sits between the CPU command path and the buzzer pin in the top level, clocked from clk_50.

---
 rtl/poly_sound_pkg.sv | 27 ++
 rtl/poly_sound_if.sv | 26 ++
 rtl/poly_sound_voice.sv | 104 ++++++++++
 rtl/poly_sound.sv | 100 ++++++++++
 4 files changed

// File: rtl/poly_sound_pkg.sv
// Shared types and constants for the poly_sound multi-voice buzzer block.
// The optional noise voices are enabled with POLY_SOUND_NOISE_EN.
package poly_sound_pkg;

  localparam int SOUND_TICK_DIV_DEFAULT = 50000;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifted right; the mask selects bits 0,2,3,5.
  localparam logic [15:0] SOUND_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] SOUND_LFSR_TAPS = 16'h002D;

  // Holding-register fields are sized for the widest supported configuration.
  localparam int SOUND_MAX_CH_W   = 8;
  localparam int SOUND_MAX_FREQ_W = 32;
  localparam int SOUND_MAX_DUR_W  = 32;

  typedef struct packed {
    logic [SOUND_MAX_CH_W-1:0]   channel;
    logic [SOUND_MAX_FREQ_W-1:0] half_period;
    logic [SOUND_MAX_DUR_W-1:0]  duration;
    logic                        noise;
  } sound_cmd_t;

  function automatic logic [15:0] sound_lfsr_next(input logic [15:0] s);
    return {^(s & SOUND_LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/poly_sound_if.sv
// Command bus into poly_sound: valid/ready handshake plus the voice command fields.
// The cmd_noise field only has an effect when POLY_SOUND_NOISE_EN is defined.
interface poly_sound_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int FREQ_WIDTH   = 16,
  parameter int DUR_WIDTH    = 12
);
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CH_W-1:0]       cmd_channel;
  logic [FREQ_WIDTH-1:0] cmd_half_period;
  logic [DUR_WIDTH-1:0]  cmd_duration;
  logic                  cmd_noise;

  modport master (
    output cmd_valid, cmd_channel, cmd_half_period, cmd_duration, cmd_noise,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_channel, cmd_half_period, cmd_duration, cmd_noise,
    output cmd_ready
  );
endinterface

// File: rtl/poly_sound_voice.sv
// One poly_sound voice: half-period counter, square phase and tick-based duration.
// With POLY_SOUND_NOISE_EN defined, a per-voice LFSR can replace the square phase.
module poly_sound_voice
  import poly_sound_pkg::*;
#(
  parameter int FREQ_WIDTH = 16,
  parameter int DUR_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FREQ_WIDTH-1:0] half_period,
  input  logic [DUR_WIDTH-1:0]  duration,
  input  logic                  noise,
  input  logic                  tick,
  output logic                  active,
  output logic                  phase
);
  localparam logic [FREQ_WIDTH-1:0] F_ONE = FREQ_WIDTH'(1);
  localparam logic [DUR_WIDTH-1:0]  D_ONE = DUR_WIDTH'(1);

  logic [FREQ_WIDTH-1:0] hp_q, hp_d, count_q, count_d;
  logic [DUR_WIDTH-1:0]  rem_q, rem_d;
  logic                  active_q, active_d, phase_q, phase_d;
`ifdef POLY_SOUND_NOISE_EN
  logic                  noise_q, noise_d;
  logic [15:0]           lfsr_q, lfsr_d;
`else
  logic                  unused_noise;
  assign unused_noise = noise;
`endif

  always_comb begin
    hp_d     = hp_q;
    count_d  = count_q;
    rem_d    = rem_q;
    active_d = active_q;
    phase_d  = phase_q;
`ifdef POLY_SOUND_NOISE_EN
    noise_d  = noise_q;
    lfsr_d   = lfsr_q;
`endif
    // A load retriggers immediately and masks any tick arriving on the same edge.
    if (load) begin
      hp_d     = half_period;
      count_d  = (half_period != '0) ? half_period - F_ONE : '0;
      phase_d  = 1'b1;
      rem_d    = duration;
      active_d = (half_period != '0);
`ifdef POLY_SOUND_NOISE_EN
      noise_d  = noise;
      lfsr_d   = SOUND_LFSR_SEED;
`endif
    end else if (active_q) begin
      if (count_q == '0) begin
        count_d = hp_q - F_ONE;
`ifdef POLY_SOUND_NOISE_EN
        if (noise_q) lfsr_d = sound_lfsr_next(lfsr_q);
        else         phase_d = ~phase_q;
`else
        phase_d = ~phase_q;
`endif
      end else begin
        count_d = count_q - F_ONE;
      end
      if (tick && rem_q != '0) begin
        rem_d = rem_q - D_ONE;
        if (rem_q == D_ONE) active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_q     <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      active_q <= 1'b0;
      phase_q  <= 1'b0;
`ifdef POLY_SOUND_NOISE_EN
      noise_q  <= 1'b0;
      lfsr_q   <= SOUND_LFSR_SEED;
`endif
    end else begin
      hp_q     <= hp_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      active_q <= active_d;
      phase_q  <= phase_d;
`ifdef POLY_SOUND_NOISE_EN
      noise_q  <= noise_d;
      lfsr_q   <= lfsr_d;
`endif
    end
  end

  assign active = active_q;
`ifdef POLY_SOUND_NOISE_EN
  assign phase = noise_q ? lfsr_q[0] : phase_q;
`else
  assign phase = phase_q;
`endif

endmodule

// File: rtl/poly_sound.sv
// poly_sound top: command holding register, duration tick prescaler and sigma-delta mixer.
// Noise voices are compiled in only when POLY_SOUND_NOISE_EN is defined.
module poly_sound
  import poly_sound_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int FREQ_WIDTH   = 16,
  parameter int DUR_WIDTH    = 12,
  parameter int TICK_DIV     = SOUND_TICK_DIV_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  poly_sound_if.slave             cmd,
  output logic [NUM_CHANNELS-1:0] channel_active,
  output logic                    buzzer
);
  localparam int SUM_W = $clog2(NUM_CHANNELS + 1);
  localparam int ACC_W = $clog2(2 * NUM_CHANNELS + 1);
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic                    ready_q, ready_d, hold_vld_q, hold_vld_d, accept;
  sound_cmd_t              hold_q, hold_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic                    tick;
  logic [SUM_W-1:0]        sum;
  logic [ACC_W-1:0]        acc_q, acc_d, acc_next;
  logic                    buzzer_q, buzzer_d;
  logic [NUM_CHANNELS-1:0] voice_active, voice_phase;
  logic                    unused_hold;

  assign unused_hold = ^hold_q;

  always_comb begin
    accept     = cmd.cmd_valid && ready_q;
    ready_d    = !accept;
    hold_vld_d = accept;
    hold_d     = hold_q;
    if (accept) begin
      hold_d.channel     = SOUND_MAX_CH_W'(cmd.cmd_channel);
      hold_d.half_period = SOUND_MAX_FREQ_W'(cmd.cmd_half_period);
      hold_d.duration    = SOUND_MAX_DUR_W'(cmd.cmd_duration);
      hold_d.noise       = cmd.cmd_noise;
    end

    tick    = (presc_q == PRE_W'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PRE_W'(1);

    // First-order sigma-delta: emit a 1 each time the accumulator wraps past NUM_CHANNELS.
    sum = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (voice_active[i] && voice_phase[i]) sum = sum + SUM_W'(1);
    end
    acc_next = acc_q + ACC_W'(sum);
    buzzer_d = (acc_next >= ACC_W'(NUM_CHANNELS));
    acc_d    = buzzer_d ? acc_next - ACC_W'(NUM_CHANNELS) : acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      hold_vld_q <= 1'b0;
      presc_q    <= '0;
      acc_q      <= '0;
      buzzer_q   <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      hold_vld_q <= hold_vld_d;
      presc_q    <= presc_d;
      acc_q      <= acc_d;
      buzzer_q   <= buzzer_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  // Channels outside 0..NUM_CHANNELS-1 match no voice, so they are dropped here.
  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_voice
    poly_sound_voice #(
      .FREQ_WIDTH (FREQ_WIDTH),
      .DUR_WIDTH  (DUR_WIDTH)
    ) u_voice (
      .clk         (clk),
      .rst         (rst),
      .load        (hold_vld_q && (hold_q.channel == SOUND_MAX_CH_W'(i))),
      .half_period (FREQ_WIDTH'(hold_q.half_period)),
      .duration    (DUR_WIDTH'(hold_q.duration)),
      .noise       (hold_q.noise),
      .tick        (tick),
      .active      (voice_active[i]),
      .phase       (voice_phase[i])
    );
  end

  assign cmd.cmd_ready   = ready_q;
  assign channel_active  = voice_active;
  assign buzzer          = buzzer_q;

endmodule
